// File: rtl/kalman_start_issuer_if.sv
`default_nettype none
// ============================================================================
// Module      : kalman_start_issuer_if
// Description : Bundles the two data paths of the start issuer:
//                 - upstream sample handshake (s_valid/s_ready/s_theta/s_phi)
//                 - filter-core side (theta_acc/phi_acc/start/finish)
//               master : the issuer itself
//               slave  : the environment (sensor front-end + kalman_fsm)
// Revision    : 1.0 - initial release
// ============================================================================
interface kalman_start_issuer_if #(
    parameter int DATA_W = 16
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_theta;
    logic signed [DATA_W-1:0] s_phi;
    logic signed [DATA_W-1:0] theta_acc;
    logic signed [DATA_W-1:0] phi_acc;
    logic                     start;
    logic                     finish;

    modport master (
        input  s_valid, s_theta, s_phi, finish,
        output s_ready, theta_acc, phi_acc, start
    );

    modport slave (
        output s_valid, s_theta, s_phi, finish,
        input  s_ready, theta_acc, phi_acc, start
    );
endinterface
`default_nettype wire

// File: rtl/kalman_start_issuer.sv
`default_nettype none
// ============================================================================
// Module      : kalman_start_issuer
// Description : Buffers accelerometer angle samples in a small FIFO and, one
//               sample at a time, presents them to kalman_fsm with a single
//               start pulse, then waits for a rising edge on finish. A
//               watchdog abandons a run that never finishes.
// Ports       : clk        - rising-edge clock
//               reset      - asynchronous reset, active low
//               bus        - sample handshake + filter-core signals (master)
//               busy       - high in LOAD/START/WAIT/DONE
//               done       - one-cycle pulse per completed run
//               timeout    - one-cycle pulse per aborted run
//               done_count - completed runs, wrapping
//               fifo_level - samples currently buffered
//               state      - debug state code
// Revision    : 1.0 - initial release
// ============================================================================
module kalman_start_issuer #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    kalman_start_issuer_if.master              bus,
    output logic                               busy,
    output logic                               done,
    output logic                               timeout,
    output logic [15:0]                        done_count,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
    output logic [2:0]                         state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = $clog2(TIMEOUT);

    localparam logic [2:0]    c_ST_IDLE  = 3'd0;
    localparam logic [2:0]    c_ST_LOAD  = 3'd1;
    localparam logic [2:0]    c_ST_START = 3'd2;
    localparam logic [2:0]    c_ST_WAIT  = 3'd3;
    localparam logic [2:0]    c_ST_DONE  = 3'd4;

    localparam logic [LW-1:0] c_LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] c_LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);
    localparam logic [WW-1:0] c_WD_MAX   = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] c_WD_ONE   = WW'(1);

    logic [2:0]               r_state;
    logic [LW-1:0]            r_level;
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic signed [DATA_W-1:0] r_theta_mem [FIFO_DEPTH];
    logic signed [DATA_W-1:0] r_phi_mem   [FIFO_DEPTH];
    logic signed [DATA_W-1:0] r_theta_acc;
    logic signed [DATA_W-1:0] r_phi_acc;
    logic                     r_finish_q;
    logic [WW-1:0]            r_wd;
    logic                     r_timeout;
    logic [15:0]              r_done_cnt;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_finish_rise;
    logic w_wd_expired;

    // Full blocks pushes even when a pop happens in the same cycle, so that
    // s_ready depends on the level alone and has no path from the FSM.
    assign w_full        = (r_level == c_LVL_FULL);
    assign w_push        = bus.s_valid & ~w_full;
    // LOAD is only entered with a non-empty FIFO and nothing else pops, so
    // the FIFO is guaranteed non-empty here.
    assign w_pop         = (r_state == c_ST_LOAD);
    // Edge detection keeps a finish level left over from the previous run
    // from completing the next one.
    assign w_finish_rise = bus.finish & ~r_finish_q;
    assign w_wd_expired  = (r_wd == c_WD_MAX);

    // Sample storage needs no reset: the level/pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_theta_mem[r_wr_ptr] <= bus.s_theta;
            r_phi_mem[r_wr_ptr]   <= bus.s_phi;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_theta_acc <= '0;
            r_phi_acc   <= '0;
            r_finish_q  <= 1'b0;
            r_wd        <= '0;
            r_timeout   <= 1'b0;
            r_done_cnt  <= '0;
        end else begin
            r_finish_q <= bus.finish;
            r_timeout  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (r_level != '0) r_state <= c_ST_LOAD;
                end
                c_ST_LOAD: begin
                    r_theta_acc <= r_theta_mem[r_rd_ptr];
                    r_phi_acc   <= r_phi_mem[r_rd_ptr];
                    r_state     <= c_ST_START;
                end
                c_ST_START: begin
                    r_wd    <= '0;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // A finish edge coinciding with expiry still counts as
                    // a completion.
                    if (w_finish_rise) begin
                        r_state <= c_ST_DONE;
                    end else if (w_wd_expired) begin
                        r_timeout <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end else begin
                        r_wd <= r_wd + c_WD_ONE;
                    end
                end
                c_ST_DONE: begin
                    r_done_cnt <= r_done_cnt + 16'd1;
                    r_state    <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.s_ready   = ~w_full;
    assign bus.theta_acc = r_theta_acc;
    assign bus.phi_acc   = r_phi_acc;
    assign bus.start     = (r_state == c_ST_START);

    assign busy       = (r_state != c_ST_IDLE);
    assign done       = (r_state == c_ST_DONE);
    assign timeout    = r_timeout;
    assign done_count = r_done_cnt;
    assign fifo_level = r_level;
    assign state      = r_state;
endmodule
`default_nettype wire

// File: tb/tb_kalman_start_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_kalman_start_issuer
// Description : Directed self-checking bench for kalman_start_issuer with
//               FIFO_DEPTH=4, TIMEOUT=16.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_kalman_start_issuer;
    localparam int DW = 16;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] done_count;
    logic [2:0]  fifo_level;
    logic [2:0]  state;

    int n_total = 0;
    int n_bad   = 0;
    int n_start = 0;
    logic [31:0] snap_q [$];
    logic [31:0] exp_q  [$];

    always #5 clk = ~clk;

    kalman_start_issuer_if #(.DATA_W(DW)) u_if ();

    kalman_start_issuer #(
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .TIMEOUT    (16)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (u_if),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .done_count (done_count),
        .fifo_level (fifo_level),
        .state      (state)
    );

    // Record what the filter would see on every start cycle.
    always @(negedge clk) begin
        if (u_if.start === 1'b1) begin
            n_start++;
            snap_q.push_back({u_if.theta_acc, u_if.phi_acc});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; a pending sample is withdrawn once it has been accepted.
    task automatic tick();
        logic acc;
        acc = u_if.s_valid & u_if.s_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            u_if.s_valid = 1'b0;
            exp_q.push_back({u_if.s_theta, u_if.s_phi});
        end
    endtask

    task automatic push(input logic [15:0] th, input logic [15:0] ph);
        u_if.s_theta = th;
        u_if.s_phi   = ph;
        u_if.s_valid = 1'b1;
        for (int i = 0; i < 40 && u_if.s_valid; i++) tick();
        chk("push_accepted", {31'd0, u_if.s_valid}, 32'd0);
    endtask

    task automatic wait_state(input logic [2:0] st, input string tag);
        for (int i = 0; i < 40 && state !== st; i++) tick();
        chk(tag, {29'd0, state}, {29'd0, st});
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        int          n;
        u_if.s_valid = 1'b0;
        u_if.s_theta = '0;
        u_if.s_phi   = '0;
        u_if.finish  = 1'b0;

        // ---------------- reset values
        #23;
        chk("rst_level",  {29'd0, fifo_level}, 32'd0);
        chk("rst_ready",  {31'd0, u_if.s_ready}, 32'd1);
        chk("rst_pulses", {28'd0, u_if.start, busy, done, timeout}, 32'd0);
        chk("rst_dcount", {16'd0, done_count}, 32'd0);
        chk("rst_state",  {29'd0, state}, 32'd0);
        chk("rst_acc",    {u_if.theta_acc, u_if.phi_acc}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- single run
        u_if.s_theta = 16'd1000;
        u_if.s_phi   = 16'd2000;
        u_if.s_valid = 1'b1;
        tick();                                         // E
        chk("s1_level",  {29'd0, fifo_level}, 32'd1);
        chk("s1_idle",   {29'd0, state}, 32'd0);
        tick();                                         // E+1
        chk("s1_load",   {29'd0, state}, 32'd1);
        tick();                                         // E+2
        chk("s1_start",  {31'd0, u_if.start}, 32'd1);
        chk("s1_acc",    {u_if.theta_acc, u_if.phi_acc}, {16'd1000, 16'd2000});
        chk("s1_popped", {29'd0, fifo_level}, 32'd0);
        chk("s1_busy",   {31'd0, busy}, 32'd1);
        tick();                                         // E+3
        chk("s1_start_low", {31'd0, u_if.start}, 32'd0);
        chk("s1_wait",   {29'd0, state}, 32'd3);
        repeat (6) tick();
        chk("s1_no_done", {31'd0, done}, 32'd0);
        u_if.finish = 1'b1;
        tick();                                         // F
        u_if.finish = 1'b0;
        chk("s1_done",   {31'd0, done}, 32'd1);
        chk("s1_dstate", {29'd0, state}, 32'd4);
        chk("s1_dc_pre", {16'd0, done_count}, 32'd0);
        tick();                                         // F+1
        chk("s1_done_low", {31'd0, done}, 32'd0);
        chk("s1_dc",     {16'd0, done_count}, 32'd1);
        chk("s1_back_idle", {29'd0, state}, 32'd0);
        chk("s1_acc_hold", {u_if.theta_acc, u_if.phi_acc}, {16'd1000, 16'd2000});
        chk("s1_one_start", n_start, 32'd1);

        // ---------------- burst / backpressure
        for (int i = 0; i < 5; i++) begin
            v = 16'(100 * (i + 1));
            push(v, -v);
        end
        // s0 already popped into the accumulators; s1..s4 fill the FIFO.
        chk("b_full_level", {29'd0, fifo_level}, 32'd4);
        chk("b_ready_low",  {31'd0, u_if.s_ready}, 32'd0);
        chk("b_in_wait",    {29'd0, state}, 32'd3);
        u_if.s_theta = 16'd600;
        u_if.s_phi   = -16'd600;
        u_if.s_valid = 1'b1;
        for (int r = 0; r < 6; r++) begin
            wait_state(3'd3, "b_wait");
            repeat (2) tick();
            u_if.finish = 1'b1;
            tick();
            u_if.finish = 1'b0;
            chk("b_done", {31'd0, done}, 32'd1);
        end
        tick();
        chk("b_dc",        {16'd0, done_count}, 32'd7);
        chk("b_drained",   {29'd0, fifo_level}, 32'd0);
        chk("b_s5_taken",  {31'd0, u_if.s_valid}, 32'd0);

        // ---------------- finish held as a level across runs
        push(16'd300, 16'd400);
        push(16'd1500, 16'd2500);
        wait_state(3'd3, "lv_w1");
        repeat (2) tick();
        u_if.finish = 1'b1;
        tick();
        chk("lv_done1", {31'd0, done}, 32'd1);
        wait_state(3'd3, "lv_w2");
        chk("lv_acc2",  {u_if.theta_acc, u_if.phi_acc}, {16'd1500, 16'd2500});
        repeat (5) tick();
        chk("lv_hold",  {29'd0, state}, 32'd3);
        chk("lv_dc_hold", {16'd0, done_count}, 32'd8);
        u_if.finish = 1'b0;
        tick();
        u_if.finish = 1'b1;
        tick();
        u_if.finish = 1'b0;
        chk("lv_done2", {31'd0, done}, 32'd1);
        tick();
        chk("lv_dc",    {16'd0, done_count}, 32'd9);

        // ---------------- watchdog abort
        push(16'd7, -16'd7);
        wait_state(3'd3, "to_wait");
        n = 0;
        for (int i = 0; i < 40 && timeout !== 1'b1; i++) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 32'd16);
        chk("to_idle",   {29'd0, state}, 32'd0);
        chk("to_dc",     {16'd0, done_count}, 32'd9);
        tick();
        chk("to_one_cycle", {31'd0, timeout}, 32'd0);

        // ---------------- finish edge exactly at expiry
        push(16'd8, -16'd8);
        wait_state(3'd3, "ex_wait");
        repeat (15) tick();
        u_if.finish = 1'b1;
        tick();
        u_if.finish = 1'b0;
        chk("ex_done",   {31'd0, done}, 32'd1);
        chk("ex_no_to",  {31'd0, timeout}, 32'd0);
        chk("ex_state",  {29'd0, state}, 32'd4);
        tick();
        chk("ex_dc",     {16'd0, done_count}, 32'd10);
        chk("ex_no_to2", {31'd0, timeout}, 32'd0);

        // ---------------- every accepted sample started once, in order
        chk("n_starts", n_start, 32'd11);
        chk("n_snaps",  snap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("start_val%0d", i), (i < snap_q.size()) ? snap_q[i] : 32'hxxxxxxxx, exp_q[i]);

        // ---------------- reset in WAIT with two samples buffered
        push(16'd21, -16'd21);
        push(16'd22, -16'd22);
        push(16'd23, -16'd23);
        wait_state(3'd3, "rs_wait");
        tick();
        chk("rs_level_pre", {29'd0, fifo_level}, 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("rs_level",  {29'd0, fifo_level}, 32'd0);
        chk("rs_ready",  {31'd0, u_if.s_ready}, 32'd1);
        chk("rs_pulses", {28'd0, u_if.start, busy, done, timeout}, 32'd0);
        chk("rs_state",  {29'd0, state}, 32'd0);
        chk("rs_acc",    {u_if.theta_acc, u_if.phi_acc}, 32'd0);
        chk("rs_dc",     {16'd0, done_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) tick();
        chk("rs_level_post", {29'd0, fifo_level}, 32'd0);
        chk("rs_no_start",   n_start, 32'd12);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
